ram_access_ctrl: RTL and testbench
==================================

Name: ram_access_ctrl

Overview:
- Initiator-side controller for the 16x8 gate-level `ram` block. It turns a one-cycle valid/ready request interface into correctly sequenced `address`, `data_in`, `write_en` and `read_en` drive.
- Address and data are set up before the enable rises and held after it falls.
- Read data is captured and returned as a single-cycle response.
- A fill command writes one value to every RAM location; it is used by the CPU reset/boot path to clear memory.

Parameters:
- ADDR_W, 4: RAM address width; the fill covers 2^ADDR_W locations.
- DATA_W, 8: RAM data width.
- WR_CYCLES, 2: number of cycles `ram_write_en` is held high per write; must be ≥1.
- RD_CYCLES, 2: number of cycles `ram_read_en` is held high per read; must be ≥1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request this cycle
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  request address
- req_wdata  input  DATA_W  write data
- fill_start  input  1  one-cycle pulse that starts a fill of the whole RAM
- fill_value  input  DATA_W  value written by the fill, sampled with fill_start
- busy  output  1  high whenever the FSM is not in IDLE
- rsp_valid  output  1  one-cycle pulse marking valid read data
- rsp_data  output  DATA_W  captured read data
- ram_address  output  ADDR_W  drives `ram.address`
- ram_write_en  output  1  drives `ram.write_en`
- ram_read_en  output  1  drives `ram.read_en`
- ram_data_in  output  DATA_W  drives `ram.data_in`
- ram_data_out  input  DATA_W  from `ram.data_out`

Behaviour:
- All ram_* outputs, rsp_valid, rsp_data and busy are registered.
- Reset: on an edge with rst=1, state=IDLE and every registered output goes to 0. The fill counter is cleared.
- req_ready is combinational: (state==IDLE) & ~fill_start & ~rst. It is therefore 0 while rst is high.
- States: IDLE, SETUP, ENABLE, HOLD.
  - Each state carries latched op∈{WR, RD, FILL}, addr and wdata.
  - An enable-cycle counter tracks cycles spent in ENABLE.
- Accept:
  - A request is accepted on a rising edge where req_valid & req_ready.
  - That edge latches req_write, req_addr and req_wdata, drives ram_address/ram_data_in, and moves the FSM to SETUP.
- SETUP (1 cycle): address and data are stable and both enables are 0. Next state is ENABLE.
- ENABLE:
  - For WR and FILL, ram_write_en=1 for exactly WR_CYCLES cycles.
  - For RD, ram_read_en=1 for exactly RD_CYCLES cycles.
  - ram_address and ram_data_in must not change while in ENABLE. Next state is HOLD.
- Read capture:
  - On the edge that leaves ENABLE, rsp_data <= ram_data_out and rsp_valid <= 1.
  - rsp_valid is therefore high for the whole HOLD cycle and low afterwards.
  - rsp_data holds its value until the next read capture.
- HOLD (1 cycle): enables are 0 and address/data are still held.
  - WR/RD: next state is IDLE.
  - FILL with addr < 2^ADDR_W−1: addr+1, then SETUP.
  - FILL with addr = 2^ADDR_W−1: IDLE. There is no wrap to 0 and no extra write.
- Latency, measured from the accept edge (cycle 0):
  - Write: SETUP is cycle 1, ENABLE is cycles 2..WR+1, HOLD is WR+2, req_ready returns at WR+3.
  - Read: rsp_valid is high in cycle RD+2, req_ready returns at RD+3.
  - With defaults, each op takes 5 cycles from accept to ready.
- Fill:
  - fill_start is honoured only in IDLE; it latches fill_value and sets addr=0, op=FILL.
  - fill_start has priority over a simultaneous req_valid; the request stays pending, unaccepted.
  - fill_start outside IDLE is ignored.
  - A fill takes 2^ADDR_W·(WR_CYCLES+2) cycles, which is 64 with defaults. busy stays high throughout.
- busy = (state != IDLE), registered.
- Outputs in IDLE: ram_address and ram_data_in keep their last values and both enables are 0.
- Reset mid-operation:
  - On the next edge, state=IDLE, enables=0, busy=0 and rsp_valid=0. Any pending response is discarded.
  - RAM locations already written keep their contents; no partial write is retried.
- At most one enable is ever high; write_en and read_en are never high simultaneously.

Test Plan:
- Reset: hold rst for 2 cycles mid-stream with req_valid=1 → all ram_* =0, rsp_valid=0, busy=0, req_ready=0 during reset and 1 the cycle after release.
- Single write: addr=3, wdata=A3 → ram_address=3 and ram_data_in=A3 stable from SETUP through HOLD; write_en high exactly 2 cycles; req_ready back 3 cycles after write_en first rises; RAM[3]=A3.
- Read back addr 3 → read_en high exactly 2 cycles; rsp_valid a single-cycle pulse 4 cycles after accept with rsp_data=A3; no write_en activity.
- Back-to-back: hold req_valid and write A0+i to addresses 0..15, then read 0..15 → 16 in-order responses A0..AF; one op accepted every 5 cycles; address never changes while either enable is high.
- Fill collision: assert fill_start with fill_value=5A together with req_valid (read addr 2) → fill wins; busy high for 64 cycles; last write at address 15; the pending read is then accepted and returns 5A; all 16 locations read 5A.
- Reset mid-fill: preload AA everywhere, start a fill of 00, assert rst while ram_address=7 in ENABLE → enables 0 and busy 0 after the next edge; RAM[0..6]=00, RAM[7] is don't-care, RAM[8..15]=AA.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: initiator-side sequencer for the 16x8 gate-level RAM.
// Converts single-cycle valid/ready requests into SETUP / ENABLE / HOLD
// sequenced RAM drive. Read data comes back as a one-cycle response.
// A fill command walks every location writing a single value.
module ram_access_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write_en,
  output logic              ram_read_en,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam int MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0]  WR_LAST   = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RD_LAST   = CNT_W'(RD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ENABLE,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    OP_WR,
    OP_RD,
    OP_FILL
  } op_t;

  state_t           state;
  op_t              op;
  logic [CNT_W-1:0] en_cnt;

  // ram_address and ram_data_in double as the latched operation address and
  // write data; during a fill ram_address is also the location counter.
  // Requests are only taken in IDLE, with fill_start masking them.
  assign req_ready = (state == IDLE) & ~fill_start & ~rst;

  // Single sequencing FSM: every RAM-facing and response output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op           <= OP_WR;
      en_cnt       <= '0;
      ram_address  <= '0;
      ram_data_in  <= '0;
      ram_write_en <= 1'b0;
      ram_read_en  <= 1'b0;
      busy         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_start) begin
            op          <= OP_FILL;
            ram_address <= '0;
            ram_data_in <= fill_value;
            state       <= SETUP;
            busy        <= 1'b1;
          end else if (req_valid) begin
            op          <= req_write ? OP_WR : OP_RD;
            ram_address <= req_addr;
            ram_data_in <= req_wdata;
            state       <= SETUP;
            busy        <= 1'b1;
          end
        end

        SETUP: begin
          state  <= ENABLE;
          en_cnt <= '0;
          if (op == OP_RD) begin
            ram_read_en <= 1'b1;
          end else begin
            ram_write_en <= 1'b1;
          end
        end

        ENABLE: begin
          if (en_cnt == ((op == OP_RD) ? RD_LAST : WR_LAST)) begin
            state        <= HOLD;
            ram_write_en <= 1'b0;
            ram_read_en  <= 1'b0;
            if (op == OP_RD) begin
              rsp_data  <= ram_data_out;
              rsp_valid <= 1'b1;
            end
          end else begin
            en_cnt <= en_cnt + CNT_W'(1);
          end
        end

        HOLD: begin
          if ((op == OP_FILL) && (ram_address != ADDR_LAST)) begin
            ram_address <= ram_address + ADDR_W'(1);
            state       <= SETUP;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed bench for ram_access_ctrl with a behavioural
// 16x8 RAM model, a response scoreboard and a protocol monitor.
module tb_ram_access_ctrl;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int WR_CYCLES = 2;
  localparam int RD_CYCLES = 2;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              fill_start;
  logic [DATA_W-1:0] fill_value;
  logic              busy;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_write_en;
  logic              ram_read_en;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  ram_access_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .WR_CYCLES(WR_CYCLES),
    .RD_CYCLES(RD_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .fill_start  (fill_start),
    .fill_value  (fill_value),
    .busy        (busy),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .ram_address (ram_address),
    .ram_write_en(ram_write_en),
    .ram_read_en (ram_read_en),
    .ram_data_in (ram_data_in),
    .ram_data_out(ram_data_out)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural RAM: synchronous write, combinational read while read_en is high
  logic [DATA_W-1:0] mem [0:15];
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_address] <= ram_data_in;
  end
  assign ram_data_out = ram_read_en ? mem[ram_address] : '0;

  int vec_count   = 0;
  int miscompares = 0;
  int accept_cyc  = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] last_wr_addr = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response and checks enable protocol
  initial begin
    logic              prev_rsp = 1'b0;
    logic              prev_we  = 1'b0;
    logic              prev_re  = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] prev_din  = '0;
    int we_run = 0;
    int re_run = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        checkOutput("rsp_single_pulse", prev_rsp, 0);
        if (exp_q.size() == 0) checkOutput("rsp_unexpected", rsp_valid, 0);
        else                   checkOutput("rsp_data", rsp_data, exp_q.pop_front());
      end
      if (ram_write_en || ram_read_en) begin
        checkOutput("one_enable", ram_write_en & ram_read_en, 0);
        if ((prev_we || prev_re) && !rst) begin
          checkOutput("addr_stable", ram_address, prev_addr);
          checkOutput("data_stable", ram_data_in, prev_din);
        end
      end
      if (ram_write_en) begin
        we_run++;
        last_wr_addr = ram_address;
      end else begin
        if (prev_we && !rst) checkOutput("we_len", we_run, WR_CYCLES);
        we_run = 0;
      end
      if (ram_read_en) begin
        re_run++;
      end else begin
        if (prev_re && !rst) checkOutput("re_len", re_run, RD_CYCLES);
        re_run = 0;
      end
      prev_rsp  = rsp_valid;
      prev_we   = ram_write_en;
      prev_re   = ram_read_en;
      prev_addr = ram_address;
      prev_din  = ram_data_in;
    end
  end

  // Presents one request, waits (bounded) for acceptance, queues read expectation
  task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_rd);
    int waitc = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    while (!req_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      checkOutput("accept_timeout", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    if (!wr) exp_q.push_back(exp_rd);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    accept_cyc = cyc;
  endtask

  // Counts negedges after an accept until req_ready returns
  task automatic waitReady(output int n, output int rsp_at, output logic saw_we);
    n = 0;
    rsp_at = 0;
    saw_we = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (rsp_valid && rsp_at == 0) rsp_at = n;
      if (ram_write_en) saw_we = 1'b1;
    end while (!req_ready && n < 200);
    if (!req_ready) checkOutput("ready_timeout", req_ready, 1);
  endtask

  // Pulses fill_start in IDLE and then scrambles fill_value to prove it was latched
  task automatic startFill(input logic [DATA_W-1:0] v);
    fill_start = 1'b1;
    fill_value = v;
    @(posedge clk);
    #1;
    fill_start = 1'b0;
    fill_value = ~v;
  endtask

  task automatic waitNotBusy(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (busy) checkOutput("busy_timeout", busy, 0);
  endtask

  // Watchdog so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    int   n, rsp_at, prev_acc, busy_cnt;
    logic saw_we;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    fill_start = 1'b0;
    fill_value = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ram_address", ram_address, 0);
    checkOutput("rst_ram_data_in", ram_data_in, 0);
    checkOutput("rst_write_en", ram_write_en, 0);
    checkOutput("rst_read_en", ram_read_en, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", req_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] single write / read");
    applyStimulus(1'b1, 4'd3, 8'hA3, 8'h00);
    waitReady(n, rsp_at, saw_we);
    checkOutput("wr_latency", n, WR_CYCLES + 3);
    checkOutput("wr_no_rsp", rsp_at, 0);
    checkOutput("ram3_written", mem[3], 8'hA3);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 4'd3, 8'h00, 8'hA3);
    waitReady(n, rsp_at, saw_we);
    checkOutput("rd_latency", n, RD_CYCLES + 3);
    checkOutput("rd_rsp_cycle", rsp_at, RD_CYCLES + 2);
    checkOutput("rd_no_write", saw_we, 0);

    $display("[TB] reset mid-read with req_valid held");
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'd3;
    @(negedge clk);
    checkOutput("midrst_ready_before", req_ready, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ready_in_rst", req_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("midrst_write_en", ram_write_en, 0);
    checkOutput("midrst_read_en", ram_read_en, 0);
    checkOutput("midrst_address", ram_address, 0);
    checkOutput("midrst_data_in", ram_data_in, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_rsp_valid", rsp_valid, 0);
    checkOutput("midrst_ready_held", req_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ready_release", req_ready, 1);
    req_valid = 1'b0;

    $display("[TB] back-to-back writes then reads");
    @(posedge clk);
    #1;
    prev_acc = -1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 4'(i), 8'hA0 + 8'(i), 8'h00);
      if (prev_acc >= 0) checkOutput("b2b_wr_interval", accept_cyc - prev_acc, 5);
      prev_acc = accept_cyc;
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 4'(i), 8'h00, 8'hA0 + 8'(i));
      checkOutput("b2b_rd_interval", accept_cyc - prev_acc, 5);
      prev_acc = accept_cyc;
    end
    waitReady(n, rsp_at, saw_we);

    $display("[TB] fill colliding with a pending read");
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'd2;
    fill_start = 1'b1;
    fill_value = 8'h5A;
    @(negedge clk);
    checkOutput("fill_masks_ready", req_ready, 0);
    @(posedge clk);
    #1;
    fill_start = 1'b0;
    fill_value = 8'h00;
    busy_cnt = 0;
    @(negedge clk);
    while (busy && busy_cnt < 200) begin
      busy_cnt++;
      @(negedge clk);
    end
    checkOutput("fill_busy_cycles", busy_cnt, 64);
    checkOutput("fill_last_addr", last_wr_addr, 15);
    checkOutput("pending_ready", req_ready, 1);
    exp_q.push_back(8'h5A);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    waitReady(n, rsp_at, saw_we);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 4'(i), 8'h00, 8'h5A);
    waitReady(n, rsp_at, saw_we);

    $display("[TB] reset in the middle of a fill");
    @(posedge clk);
    #1;
    startFill(8'hAA);
    waitNotBusy(n);
    checkOutput("preload_cycles", n, 64);
    @(posedge clk);
    #1;
    startFill(8'h00);
    n = 0;
    @(negedge clk);
    while (!(ram_write_en && ram_address == 4'd7) && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput("fill_reach_addr7", ram_address, 7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("fillrst_write_en", ram_write_en, 0);
    checkOutput("fillrst_read_en", ram_read_en, 0);
    checkOutput("fillrst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 7; i++)  checkOutput("fillrst_low_cleared", mem[i], 8'h00);
    for (int i = 8; i < 16; i++) checkOutput("fillrst_high_kept", mem[i], 8'hAA);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
